// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the round-robin arbiter
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Widest vector onehot_to_idx accepts; narrower vectors are zero-extended by the caller.
    localparam int ARB_MAX_W = 64;

    function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pri.sv
// rtl/pri.sv - combinational priority selector, highest set index wins
module pri #(
    parameter int W = 4
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < W; i++) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter with registered, acknowledge-held one-hot grant
module rr_arb
    import arb_pkg::*;
#(
    parameter int W     = 4,
    parameter int ENC_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     i_req,
    input  logic             i_ack,
    output logic             o_gnt_vld,
    output logic [W-1:0]     o_gnt,
    output logic [ENC_W-1:0] o_gnt_enc
);

    arb_state_t       state_q, state_d;
    logic [W-1:0]     mask_q, mask_d;
    logic [W-1:0]     gnt_q, gnt_d;
    logic [ENC_W-1:0] enc_q, enc_d;

    logic [W-1:0]     req_m;
    logic [W-1:0]     gnt_m;
    logic [W-1:0]     gnt_u;
    logic [W-1:0]     pick;
    logic             ack_hit;

    // The ack cycle already searches with the post-ack mask so the next grant has no bubble.
    assign ack_hit = (state_q == ARB_GRANT) && i_ack;
    assign mask_d  = ack_hit ? (gnt_q - W'(1)) : mask_q;
    assign req_m   = i_req & mask_d;
    assign pick    = (|req_m) ? gnt_m : gnt_u;

    pri #(.W(W)) u_pri_masked (
        .req (req_m),
        .gnt (gnt_m)
    );

    pri #(.W(W)) u_pri_unmasked (
        .req (i_req),
        .gnt (gnt_u)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        enc_d   = enc_q;
        if ((state_q == ARB_IDLE) || ack_hit) begin
            if (|i_req) begin
                state_d = ARB_GRANT;
                gnt_d   = pick;
                enc_d   = ENC_W'(onehot_to_idx(ARB_MAX_W'(pick)));
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                enc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            mask_q  <= '1;
            gnt_q   <= '0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            gnt_q   <= gnt_d;
            enc_q   <= enc_d;
        end
    end

    assign o_gnt_vld = (state_q == ARB_GRANT);
    assign o_gnt     = gnt_q;
    assign o_gnt_enc = enc_q;

endmodule

// File: tb/tb_rr_arb.sv
// tb/tb_rr_arb.sv - directed self-checking bench for rr_arb
module tb_rr_arb;

    localparam int W     = 4;
    localparam int ENC_W = 2;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     i_req;
    logic             i_ack;
    logic             o_gnt_vld;
    logic [W-1:0]     o_gnt;
    logic [ENC_W-1:0] o_gnt_enc;

    int n_checks;
    int n_errors;

    rr_arb #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_ack     (i_ack),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt     (o_gnt),
        .o_gnt_enc (o_gnt_enc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [W-1:0] g, input int e);
        chk({tag, ".vld"}, 32'(o_gnt_vld), 32'(1));
        chk({tag, ".gnt"}, 32'(o_gnt), 32'(g));
        chk({tag, ".enc"}, 32'(o_gnt_enc), 32'(e));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".vld"}, 32'(o_gnt_vld), 32'(0));
        chk({tag, ".gnt"}, 32'(o_gnt), 32'(0));
        chk({tag, ".enc"}, 32'(o_gnt_enc), 32'(0));
    endtask

    logic [W-1:0] exp_rot [5];
    int           exp_idx [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_rot = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        exp_idx = '{3, 2, 1, 0, 3};

        rst_n = 1'b0; i_req = '0; i_ack = 1'b0;
        cyc(); cyc();
        chk_idle("reset");
        rst_n = 1'b1;

        // Full rotation with every grant acknowledged.
        i_req = 4'b1111; i_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_gnt($sformatf("rot%0d", i), exp_rot[i], exp_idx[i]);
        end
        i_req = '0;
        cyc();
        chk_idle("rot_end");

        // Lock: grant held without ack, even after its request drops.
        i_req = 4'b0101; i_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_gnt($sformatf("hold%0d", i), 4'b0100, 2);
        end
        i_req = 4'b0001;
        cyc();
        chk_gnt("hold_drop", 4'b0100, 2);
        i_ack = 1'b1;
        cyc();
        chk_gnt("hold_next", 4'b0001, 0);
        i_req = '0;
        cyc();
        chk_idle("hold_end");

        // Single requester regranted back to back.
        i_req = 4'b0010; i_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_gnt($sformatf("single%0d", i), 4'b0010, 1);
        end
        i_req = '0;
        cyc();
        chk_idle("single_end");

        // Serving index 0 empties the mask, so the search wraps to the top.
        i_req = 4'b0001; i_ack = 1'b1;
        cyc();
        chk_gnt("wrap0", 4'b0001, 0);
        i_req = 4'b1001;
        cyc();
        chk_gnt("wrap3", 4'b1000, 3);
        i_req = '0;
        cyc();
        chk_idle("wrap_end");

        // Reset mid-grant drops the grant and restores the all-ones mask.
        i_req = 4'b0100; i_ack = 1'b0;
        cyc();
        chk_gnt("mid_gnt", 4'b0100, 2);
        rst_n = 1'b0; i_req = 4'b1111;
        cyc();
        chk_idle("mid_rst");
        rst_n = 1'b1;
        cyc();
        chk_gnt("post_rst", 4'b1000, 3);

        // Stray ack in IDLE right after reset leaves the mask alone.
        rst_n = 1'b0; i_req = '0; i_ack = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk_idle("stray_idle");
        i_req = 4'b0110; i_ack = 1'b0;
        cyc();
        chk_gnt("stray_gnt", 4'b0100, 2);

        // Mask is now 0011 after acking index 2; a stray ack must not disturb it.
        i_req = '0; i_ack = 1'b1;
        cyc();
        chk_idle("stray2_idle");
        cyc();
        i_req = 4'b0110; i_ack = 1'b0;
        cyc();
        chk_gnt("stray2_gnt", 4'b0010, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
